prbs_cfg_sequencer: RTL and testbench

Configuration sequencer for the PRBS channel. It accepts a complete PRBS parameter set (PN order, bit rate, edge time, amplitude, DC offset) in one start handshake and plays it into the channel register file as a burst of byte writes on the `CH_CONFIG_WE/ADDR/DATA` bus. The burst is bracketed by a load-protect window so the DAC-side generator never runs on a half-written parameter set. The block runs in the `CLK_LOW` configuration domain, between the host/command decoder and `CHANNEL_REG_CONFIG`.

---
 rtl/prbs_cfg_sequencer.sv | 179 +++++++++++++++++
 tb/tb_prbs_cfg_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_cfg_sequencer.sv
// Plays a captured PRBS parameter set into the channel register file as a
// protected burst of byte writes, with a one-deep pending slot for restarts.
`timescale 1ns/1ps
module prbs_cfg_sequencer #(
  parameter int SETUP_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic        CLK_LOW,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic [4:0]  cfg_field_mask,
  input  logic [4:0]  cfg_pn_select,
  input  logic [31:0] cfg_bit_rate,
  input  logic [7:0]  cfg_edge_time,
  input  logic [15:0] cfg_amplitude,
  input  logic [15:0] cfg_dc_offset,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_overrun,
  output logic        cfg_protect,
  output logic        CH_CONFIG_WE,
  output logic [7:0]  CH_CONFIG_ADDR,
  output logic [7:0]  CH_CONFIG_DATA
);

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] GAP_LAST   = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [3:0] NUM_BYTES  = 4'd10;

  typedef struct packed {
    logic [4:0]  mask;
    logic [4:0]  pn;
    logic [31:0] rate;
    logic [7:0]  edge_time;
    logic [15:0] amp;
    logic [15:0] offset;
  } cfg_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRE, S_WR, S_GAP, S_POST, S_DONE
  } state_t;

  state_t     state, state_n;
  cfg_t       cfg_in, sh, pd;
  logic       pend;
  logic [3:0] cnt, idx, wr_idx, first_idx, nxt_idx;
  logic       load_byte, reload, any_start;
  logic [4:0] next_mask;
  logic [7:0] wr_byte;

  function automatic logic byte_en(input logic [4:0] mask, input logic [3:0] i);
    case (i)
      4'd0:                   byte_en = mask[0];
      4'd1, 4'd2, 4'd3, 4'd4: byte_en = mask[1];
      4'd5:                   byte_en = mask[2];
      4'd6, 4'd7:             byte_en = mask[3];
      4'd8, 4'd9:             byte_en = mask[4];
      default:                byte_en = 1'b0;
    endcase
  endfunction

  // Lowest enabled byte index at or above 'from'; NUM_BYTES when none remain.
  function automatic logic [3:0] next_en(input logic [4:0] mask, input logic [3:0] from);
    logic [3:0] r;
    r = NUM_BYTES;
    for (int i = 9; i >= 0; i--) begin
      if (4'(i) >= from && byte_en(mask, 4'(i))) r = 4'(i);
    end
    return r;
  endfunction

  assign cfg_in    = {cfg_field_mask, cfg_pn_select, cfg_bit_rate, cfg_edge_time,
                      cfg_amplitude, cfg_dc_offset};
  assign first_idx = next_en(sh.mask, 4'd0);
  assign nxt_idx   = next_en(sh.mask, idx + 4'd1);
  assign any_start = cfg_start || pend;
  assign next_mask = cfg_start ? cfg_field_mask : pd.mask;
  assign reload    = (state == S_DONE) && any_start;

  always_comb begin
    state_n   = state;
    load_byte = 1'b0;
    wr_idx    = idx;
    case (state)
      S_IDLE: if (cfg_start) state_n = S_LOAD;
      // An empty set still takes the same two-cycle acknowledge latency.
      S_LOAD: begin
        if (sh.mask != 5'd0)  state_n = S_PRE;
        else if (cnt == 4'd1) state_n = S_DONE;
      end
      S_PRE: begin
        if (cnt == SETUP_LAST) begin
          state_n   = S_WR;
          load_byte = 1'b1;
          wr_idx    = first_idx;
        end
      end
      S_WR: begin
        if (nxt_idx == NUM_BYTES) begin
          state_n = S_POST;
        end else if (GAP_CYCLES == 0) begin
          state_n   = S_WR;
          load_byte = 1'b1;
          wr_idx    = nxt_idx;
        end else begin
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n   = S_WR;
          load_byte = 1'b1;
          wr_idx    = idx;
        end
      end
      S_POST: if (cnt == SETUP_LAST) state_n = S_DONE;
      S_DONE: begin
        if (any_start) state_n = (next_mask != 5'd0) ? S_PRE : S_DONE;
        else           state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    wr_byte = 8'h00;
    case (wr_idx)
      4'd0:    wr_byte = {3'b000, sh.pn};
      4'd1:    wr_byte = sh.rate[7:0];
      4'd2:    wr_byte = sh.rate[15:8];
      4'd3:    wr_byte = sh.rate[23:16];
      4'd4:    wr_byte = sh.rate[31:24];
      4'd5:    wr_byte = sh.edge_time;
      4'd6:    wr_byte = sh.amp[7:0];
      4'd7:    wr_byte = sh.amp[15:8];
      4'd8:    wr_byte = sh.offset[7:0];
      4'd9:    wr_byte = sh.offset[15:8];
      default: wr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge CLK_LOW) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      idx            <= 4'd0;
      pend           <= 1'b0;
      cfg_overrun    <= 1'b0;
      CH_CONFIG_ADDR <= 8'h00;
      CH_CONFIG_DATA <= 8'h00;
    end else begin
      state       <= state_n;
      cnt         <= (state_n != state) ? 4'd0 : cnt + 4'd1;
      cfg_overrun <= cfg_start && (state != S_IDLE) && pend;
      if (load_byte) begin
        idx            <= wr_idx;
        CH_CONFIG_ADDR <= {4'h0, wr_idx};
        CH_CONFIG_DATA <= wr_byte;
      end else if (state == S_WR) begin
        idx <= nxt_idx;
      end
      if (reload)                               pend <= 1'b0;
      else if (cfg_start && (state != S_IDLE))  pend <= 1'b1;
    end
  end

  // Parameter sets are pure data and carry no reset.
  always_ff @(posedge CLK_LOW) begin
    if ((state == S_IDLE) && cfg_start) sh <= cfg_in;
    else if (reload)                    sh <= cfg_start ? cfg_in : pd;
    if (cfg_start && (state != S_IDLE)) pd <= cfg_in;
  end

  assign cfg_busy     = (state == S_PRE) || (state == S_WR) || (state == S_GAP) || (state == S_POST);
  assign cfg_protect  = cfg_busy;
  assign cfg_done     = (state == S_DONE);
  assign CH_CONFIG_WE = (state == S_WR);

endmodule

// File: tb/tb_prbs_cfg_sequencer.sv
// Directed bench for prbs_cfg_sequencer: default timing instance plus a
// zero-gap instance; cycle j means "observed just after edge k+j".
`timescale 1ns/1ps
module tb_prbs_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [4:0]  mask = '0, pn = '0;
  logic [31:0] rate = '0;
  logic [7:0]  edge_time = '0;
  logic [15:0] amp = '0, offset = '0;

  logic busy0, done0, ovr0, prot0, we0;
  logic [7:0] addr0, data0;
  logic busy1, done1, ovr1, prot1, we1;
  logic [7:0] addr1, data1;

  prbs_cfg_sequencer #(.SETUP_CYCLES(2), .GAP_CYCLES(1)) dut0 (
    .CLK_LOW(clk), .reset(reset), .cfg_start(start0), .cfg_field_mask(mask),
    .cfg_pn_select(pn), .cfg_bit_rate(rate), .cfg_edge_time(edge_time),
    .cfg_amplitude(amp), .cfg_dc_offset(offset), .cfg_busy(busy0),
    .cfg_done(done0), .cfg_overrun(ovr0), .cfg_protect(prot0),
    .CH_CONFIG_WE(we0), .CH_CONFIG_ADDR(addr0), .CH_CONFIG_DATA(data0));

  prbs_cfg_sequencer #(.SETUP_CYCLES(2), .GAP_CYCLES(0)) dut1 (
    .CLK_LOW(clk), .reset(reset), .cfg_start(start1), .cfg_field_mask(mask),
    .cfg_pn_select(pn), .cfg_bit_rate(rate), .cfg_edge_time(edge_time),
    .cfg_amplitude(amp), .cfg_dc_offset(offset), .cfg_busy(busy1),
    .cfg_done(done1), .cfg_overrun(ovr1), .cfg_protect(prot1),
    .CH_CONFIG_WE(we1), .CH_CONFIG_ADDR(addr1), .CH_CONFIG_DATA(data1));

  int checks = 0;
  int errors = 0;

  logic       we_a [0:63];
  logic       done_a [0:63];
  logic       prot_a [0:63];
  logic       busy_a [0:63];
  logic       ovr_a [0:63];
  logic [7:0] addr_a [0:63];
  logic [7:0] data_a [0:63];

  logic [7:0] full_data [0:9];

  task automatic sample(input int j, input bit use1);
    we_a[j]   = use1 ? we1   : we0;
    done_a[j] = use1 ? done1 : done0;
    prot_a[j] = use1 ? prot1 : prot0;
    busy_a[j] = use1 ? busy1 : busy0;
    ovr_a[j]  = use1 ? ovr1  : ovr0;
    addr_a[j] = use1 ? addr1 : addr0;
    data_a[j] = use1 ? data1 : data0;
  endtask

  task automatic set_inputs(input logic [4:0] m, input logic [4:0] p, input logic [31:0] r,
                            input logic [7:0] e, input logic [15:0] a, input logic [15:0] o);
    mask = m; pn = p; rate = r; edge_time = e; amp = a; offset = o;
  endtask

  // Start is sampled at the next edge (edge k); returns just after it.
  task automatic pulse_start(input bit use1);
    if (use1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy0, done0, ovr0, prot0, we0, addr0, data0} !== 21'd0) begin
      errors++;
      $display("FAIL reset_dut0 got %h expected 0", {busy0, done0, ovr0, prot0, we0, addr0, data0});
    end
    checks++;
    if ({busy1, done1, ovr1, prot1, we1, addr1, data1} !== 21'd0) begin
      errors++;
      $display("FAIL reset_dut1 got %h expected 0", {busy1, done1, ovr1, prot1, we1, addr1, data1});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_write;
    logic exp_we, exp_act;
    set_inputs(5'h1F, 5'd2, 32'h0200_0000, 8'd16, 16'h8000, 16'h0000);
    pulse_start(1'b0);
    for (int j = 1; j <= 26; j++) begin
      @(posedge clk); #1;
      sample(j, 1'b0);
    end
    for (int j = 1; j <= 26; j++) begin
      exp_we  = (j >= 3) && (j <= 21) && (j % 2 == 1);
      exp_act = (j >= 1) && (j <= 23);
      checks++;
      if (we_a[j] !== exp_we) begin
        errors++; $display("FAIL full_we j=%0d got %b expected %b", j, we_a[j], exp_we);
      end
      if (exp_we) begin
        checks++;
        if (addr_a[j] !== 8'((j - 3) / 2) || data_a[j] !== full_data[(j - 3) / 2]) begin
          errors++;
          $display("FAIL full_byte j=%0d got %h/%h expected %h/%h", j, addr_a[j], data_a[j],
                   8'((j - 3) / 2), full_data[(j - 3) / 2]);
        end
      end
      checks++;
      if (done_a[j] !== (j == 24)) begin
        errors++; $display("FAIL full_done j=%0d got %b expected %b", j, done_a[j], (j == 24));
      end
      checks++;
      if (prot_a[j] !== exp_act || busy_a[j] !== exp_act) begin
        errors++;
        $display("FAIL full_protect_busy j=%0d got %b%b expected %b", j, prot_a[j], busy_a[j], exp_act);
      end
    end
  endtask

  task automatic test_partial_mask;
    set_inputs(5'b00100, 5'd0, 32'd0, 8'd8, 16'd0, 16'd0);
    pulse_start(1'b1);
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1;
      sample(j, 1'b1);
    end
    for (int j = 1; j <= 8; j++) begin
      checks++;
      if (we_a[j] !== (j == 3)) begin
        errors++; $display("FAIL partial_we j=%0d got %b expected %b", j, we_a[j], (j == 3));
      end
      checks++;
      if (done_a[j] !== (j == 6)) begin
        errors++; $display("FAIL partial_done j=%0d got %b expected %b", j, done_a[j], (j == 6));
      end
      checks++;
      if (prot_a[j] !== (j <= 5)) begin
        errors++; $display("FAIL partial_protect j=%0d got %b expected %b", j, prot_a[j], (j <= 5));
      end
    end
    checks++;
    if (addr_a[3] !== 8'h05 || data_a[3] !== 8'h08) begin
      errors++; $display("FAIL partial_byte got %h/%h expected 05/08", addr_a[3], data_a[3]);
    end
  endtask

  task automatic test_zero_mask;
    set_inputs(5'b00000, 5'd3, 32'hFFFF_FFFF, 8'hFF, 16'hFFFF, 16'hFFFF);
    pulse_start(1'b0);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      sample(j, 1'b0);
    end
    for (int j = 1; j <= 6; j++) begin
      checks++;
      if (we_a[j] !== 1'b0 || prot_a[j] !== 1'b0 || busy_a[j] !== 1'b0) begin
        errors++;
        $display("FAIL zero_quiet j=%0d got we=%b prot=%b busy=%b expected 000", j, we_a[j], prot_a[j], busy_a[j]);
      end
      checks++;
      if (done_a[j] !== (j == 2)) begin
        errors++; $display("FAIL zero_done j=%0d got %b expected %b", j, done_a[j], (j == 2));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic exp_we, exp_prot;
    set_inputs(5'h1F, 5'd2, 32'h0200_0000, 8'd16, 16'h8000, 16'h0000);
    pulse_start(1'b0);
    for (int j = 1; j <= 34; j++) begin
      @(posedge clk); #1;
      sample(j, 1'b0);
      if (j == 5)  begin set_inputs(5'b00100, 5'd0, 32'd0, 8'd32, 16'd0, 16'd0); start0 = 1'b1; end
      if (j == 6)  start0 = 1'b0;
      if (j == 10) begin edge_time = 8'd1; start0 = 1'b1; end
      if (j == 11) start0 = 1'b0;
    end
    for (int j = 1; j <= 34; j++) begin
      exp_we   = ((j >= 3) && (j <= 21) && (j % 2 == 1)) || (j == 27);
      exp_prot = ((j >= 1) && (j <= 23)) || ((j >= 25) && (j <= 29));
      checks++;
      if (ovr_a[j] !== (j == 11)) begin
        errors++; $display("FAIL b2b_overrun j=%0d got %b expected %b", j, ovr_a[j], (j == 11));
      end
      checks++;
      if (done_a[j] !== ((j == 24) || (j == 30))) begin
        errors++; $display("FAIL b2b_done j=%0d got %b expected %b", j, done_a[j], ((j == 24) || (j == 30)));
      end
      checks++;
      if (we_a[j] !== exp_we) begin
        errors++; $display("FAIL b2b_we j=%0d got %b expected %b", j, we_a[j], exp_we);
      end
      checks++;
      if (prot_a[j] !== exp_prot) begin
        errors++; $display("FAIL b2b_protect j=%0d got %b expected %b", j, prot_a[j], exp_prot);
      end
    end
    checks++;
    if (addr_a[13] !== 8'h05 || data_a[13] !== 8'h10) begin
      errors++; $display("FAIL b2b_first_edge got %h/%h expected 05/10", addr_a[13], data_a[13]);
    end
    checks++;
    if (addr_a[27] !== 8'h05 || data_a[27] !== 8'h01) begin
      errors++; $display("FAIL b2b_second_edge got %h/%h expected 05/01", addr_a[27], data_a[27]);
    end
  endtask

  task automatic test_reset_mid_burst;
    set_inputs(5'h1F, 5'd7, 32'hA5A5_5A5A, 8'd3, 16'h1234, 16'h5678);
    pulse_start(1'b0);
    for (int j = 1; j <= 9; j++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (we0 !== 1'b1 || addr0 !== 8'h03) begin
      errors++; $display("FAIL mid_fourth_we got we=%b addr=%h expected 1/03", we0, addr0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy0, done0, ovr0, prot0, we0, addr0, data0} !== 21'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h expected 0", {busy0, done0, ovr0, prot0, we0, addr0, data0});
    end
    reset = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1;
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0 || we0 !== 1'b0) begin
        errors++;
        $display("FAIL mid_abandoned t=%0d got done=%b busy=%b we=%b expected 000", j, done0, busy0, we0);
      end
    end
    test_full_write();
  endtask

  task automatic test_input_stability;
    logic [7:0] exp_rate [0:3];
    exp_rate[0] = 8'h78; exp_rate[1] = 8'h56; exp_rate[2] = 8'h34; exp_rate[3] = 8'h12;
    set_inputs(5'h1F, 5'd2, 32'h1234_5678, 8'd16, 16'h8000, 16'h0000);
    pulse_start(1'b0);
    for (int j = 1; j <= 26; j++) begin
      @(posedge clk); #1;
      sample(j, 1'b0);
      if (j == 1) rate = 32'hFFFF_FFFF;
      if (j == 8) rate = 32'h0BAD_F00D;
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (we_a[5 + 2 * b] !== 1'b1 || addr_a[5 + 2 * b] !== 8'(b + 1) || data_a[5 + 2 * b] !== exp_rate[b]) begin
        errors++;
        $display("FAIL stable_rate b=%0d got we=%b %h/%h expected 1 %h/%h", b, we_a[5 + 2 * b],
                 addr_a[5 + 2 * b], data_a[5 + 2 * b], 8'(b + 1), exp_rate[b]);
      end
    end
    checks++;
    if (done_a[24] !== 1'b1) begin
      errors++; $display("FAIL stable_done got %b expected 1", done_a[24]);
    end
    rate = 32'd0;
  endtask

  initial begin
    full_data[0] = 8'h02; full_data[1] = 8'h00; full_data[2] = 8'h00; full_data[3] = 8'h00;
    full_data[4] = 8'h02; full_data[5] = 8'h10; full_data[6] = 8'h00; full_data[7] = 8'h80;
    full_data[8] = 8'h00; full_data[9] = 8'h00;
    test_reset();
    test_full_write();
    test_partial_mask();
    test_zero_mask();
    test_back_to_back();
    test_reset_mid_burst();
    test_input_stability();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
